// File: rtl/packet_rr_arbiter.sv
// packet_rr_arbiter
//   Wormhole arbiter sharing one switch output port among PORTS upstream
//   requesters. The port is granted per packet (head to tail) in round-robin
//   order. While a packet owns the port, its req/data are muxed downstream
//   and the downstream ack is routed back to it. A flit watchdog forces
//   release after MAX_FLITS flits without a tail.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   gen_enable        permits new grants (in-flight packet always completes)
//   req_up_i          per-requester flit valid
//   Data_up_i         per-requester flit data, requester i at [i*WIDTH +: WIDTH]
//   tail_up_i         per-requester tail marker for the current flit
//   ack_up_o          per-requester flit accepted
//   req_dw_o          flit valid to output port
//   Data_dw_o         flit data to output port (0 when idle)
//   ack_dw_i          output port accepts flit
//   Tailpassed_dw_o   one-cycle pulse: tail flit transferred
//   grant_o           one-hot current owner, 0 when idle
//   busy_o            port owned by a packet
//   err_o             one-cycle pulse: watchdog forced release
module packet_rr_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned PORTS     = 4,
  parameter int unsigned MAX_FLITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gen_enable,
  input  logic [PORTS-1:0]       req_up_i,
  input  logic [PORTS*WIDTH-1:0] Data_up_i,
  input  logic [PORTS-1:0]       tail_up_i,
  output logic [PORTS-1:0]       ack_up_o,
  output logic                   req_dw_o,
  output logic [WIDTH-1:0]       Data_dw_o,
  input  logic                   ack_dw_i,
  output logic                   Tailpassed_dw_o,
  output logic [PORTS-1:0]       grant_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int unsigned PW = $clog2(PORTS);
  localparam int unsigned CW = $clog2(MAX_FLITS + 1);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [PORTS-1:0] grant_q, grant_d;
  logic [PW-1:0]    ptr_q,   ptr_d;
  logic [CW-1:0]    cnt_q,   cnt_d;

  logic [PW-1:0]    owner;
  logic             found;
  logic [PW-1:0]    win;
  int unsigned      idx;
  logic             xfer;
  logic             tail_xfer;
  logic             wd_xfer;

  // Owner index recovered from the one-hot grant register.
  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (grant_q[i]) owner = PW'(i);
    end
  end

  // Round-robin search starting at ptr_q; first requesting index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = (32'(ptr_q) + k) % PORTS;
      if (!found && req_up_i[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Combinational datapath: everything is forced to zero outside LOCKED,
  // which also makes reset drop the port asynchronously.
  always_comb begin
    req_dw_o  = 1'b0;
    Data_dw_o = '0;
    ack_up_o  = '0;
    xfer      = 1'b0;
    tail_xfer = 1'b0;
    wd_xfer   = 1'b0;
    if (state_q == LOCKED) begin
      req_dw_o        = req_up_i[owner];
      Data_dw_o       = Data_up_i[owner*WIDTH +: WIDTH];
      ack_up_o[owner] = ack_dw_i & req_up_i[owner];
      xfer            = req_up_i[owner] & ack_dw_i;
      tail_xfer       = xfer & tail_up_i[owner];
      // Tail has priority over the watchdog on the same flit.
      wd_xfer         = xfer & ~tail_up_i[owner] & (cnt_q == CW'(MAX_FLITS - 1));
    end
  end

  assign Tailpassed_dw_o = tail_xfer;
  assign err_o           = wd_xfer;
  assign grant_o         = grant_q;
  assign busy_o          = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (gen_enable && found) begin
          state_d      = LOCKED;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          cnt_d        = '0;
          ptr_d        = (win == PW'(PORTS - 1)) ? '0 : win + 1'b1;
        end
      end
      LOCKED: begin
        if (tail_xfer || wd_xfer) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
